// File: rtl/vx_barrier_table.sv
// ---------------------------------------------------------------------------
// vx_barrier_table
//
// Multi-barrier warp synchronisation table. Warps arrive at a barrier id and
// say how many warps take part (size_m1 = participants - 1). The table keeps
// the arrived-warp mask per barrier, drives a registered stall mask of every
// waiting warp, and emits one release event per completed barrier through a
// one-deep, back-pressured release register.
//
// Optional feature (macro BARRIER_TIMEOUT_EN):
//   When defined, every open barrier carries an age counter. After
//   TIMEOUT_CYCLES cycles the barrier is force-released with rel_timeout=1.
//   When undefined there are no age counters and rel_timeout stays 0.
//
// Ports:
//   clk          core clock
//   reset        synchronous, active-high reset
//   req_valid    arrival request valid
//   req_ready    arrival accepted when valid & ready (= !rel_valid | rel_ready)
//   req_wid      arriving warp id
//   req_bid      barrier id
//   req_size_m1  participating warps minus one (first arrival's value governs)
//   rel_valid    release event valid (held until rel_ready)
//   rel_ready    consumer accepts release
//   rel_bid      released barrier id
//   rel_mask     warps to unstall
//   rel_timeout  release was forced by timeout
//   stall_mask   warps currently waiting at any barrier
//   err_dup      one-cycle pulse: duplicate arrival ignored
// ---------------------------------------------------------------------------
module vx_barrier_table #(
    parameter int NUM_WARPS      = 4,
    parameter int NUM_BARRIERS   = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int NW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NB = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW-1:0]        req_wid,
    input  logic [NB-1:0]        req_bid,
    input  logic [NW-1:0]        req_size_m1,
    output logic                 rel_valid,
    input  logic                 rel_ready,
    output logic [NB-1:0]        rel_bid,
    output logic [NUM_WARPS-1:0] rel_mask,
    output logic                 rel_timeout,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 err_dup
);

    localparam int CW = NW + 1;

    logic                    accept;
    logic [NUM_WARPS-1:0]    wid_onehot;

    logic                    rel_valid_reg;
    logic [NB-1:0]           rel_bid_reg;
    logic [NUM_WARPS-1:0]    rel_mask_reg;
    logic                    rel_timeout_reg;
    logic [NUM_WARPS-1:0]    stall_mask_reg;
    logic                    err_dup_reg;

    logic [NUM_BARRIERS-1:0] hit_vec;
    logic [NUM_BARRIERS-1:0] dup_vec;
    logic [NUM_BARRIERS-1:0] done_vec;
    logic [NUM_BARRIERS-1:0] to_req_vec;
    logic [NUM_BARRIERS-1:0] grant_vec;
    logic [NUM_WARPS-1:0]    cur_mask [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]    nxt_mask [NUM_BARRIERS];

    logic                    any_done;
    logic                    any_grant;
    logic [NUM_WARPS-1:0]    done_mask;
    logic [NB-1:0]           tout_bid;
    logic [NUM_WARPS-1:0]    tout_mask;
    logic [NUM_WARPS-1:0]    stall_next;

    assign req_ready  = !rel_valid_reg || rel_ready;
    assign accept     = req_valid && req_ready;
    assign wid_onehot = NUM_WARPS'(1) << req_wid;

    // -----------------------------------------------------------------------
    // Barrier entries
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_entry
        logic                 active_reg, active_next;
        logic [NW-1:0]        count_reg, count_next;
        logic [NW-1:0]        size_reg, size_next;
        logic [NUM_WARPS-1:0] mask_reg, mask_next;
        logic                 hit, dup, done;

        assign hit  = accept && (req_bid == NB'(gi));
        assign dup  = hit && active_reg && ((mask_reg & wid_onehot) != '0);
        // count holds arrivals-1, so the arrival that makes count reach
        // size_m1 is the last participant.
        assign done = hit && (active_reg
                      ? (!dup && (({1'b0, count_reg} + CW'(1)) == {1'b0, size_reg}))
                      : (req_size_m1 == '0));

        always_comb begin
            active_next = active_reg;
            count_next  = count_reg;
            size_next   = size_reg;
            mask_next   = mask_reg;
            if (done || grant_vec[gi]) begin
                active_next = 1'b0;
                count_next  = '0;
                mask_next   = '0;
            end else if (hit && !active_reg) begin
                active_next = 1'b1;
                size_next   = req_size_m1;
                mask_next   = wid_onehot;
                count_next  = '0;
            end else if (hit && !dup) begin
                mask_next  = mask_reg | wid_onehot;
                count_next = count_reg + NW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                active_reg <= 1'b0;
                count_reg  <= '0;
                size_reg   <= '0;
                mask_reg   <= '0;
            end else begin
                active_reg <= active_next;
                count_reg  <= count_next;
                size_reg   <= size_next;
                mask_reg   <= mask_next;
            end
        end

`ifdef BARRIER_TIMEOUT_EN
        localparam int AW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
        logic [AW-1:0] age_reg;

        // Age saturates at the limit so a losing entry keeps requesting.
        always_ff @(posedge clk) begin
            if (reset) begin
                age_reg <= '0;
            end else if (hit && !active_reg) begin
                age_reg <= '0;
            end else if (active_reg && (age_reg != AW'(TIMEOUT_CYCLES))) begin
                age_reg <= age_reg + AW'(1);
            end
        end

        // An entry taking an arrival this cycle defers its forced release by
        // a cycle so the arriving warp is never dropped.
        assign to_req_vec[gi] = active_reg && (age_reg == AW'(TIMEOUT_CYCLES)) && !hit;
`else
        assign to_req_vec[gi] = 1'b0;
`endif

        assign hit_vec[gi]  = hit;
        assign dup_vec[gi]  = dup;
        assign done_vec[gi] = done;
        assign cur_mask[gi] = mask_reg;
        assign nxt_mask[gi] = mask_next;
    end

    // -----------------------------------------------------------------------
    // Completion / forced-release selection and stall aggregation
    // -----------------------------------------------------------------------
    always_comb begin
        any_done  = |done_vec;
        grant_vec = '0;
        tout_bid  = '0;
        tout_mask = '0;
        // Forced releases only use a slot that a real completion leaves free.
        // Descending scan so the lowest requesting bid is the one kept.
        for (int b = NUM_BARRIERS - 1; b >= 0; b--) begin
            if (!any_done && (!rel_valid_reg || rel_ready) && to_req_vec[b]) begin
                grant_vec = NUM_BARRIERS'(1) << b;
                tout_bid  = NB'(b);
                tout_mask = cur_mask[b];
            end
        end
        any_grant = |grant_vec;

        done_mask  = wid_onehot;
        stall_next = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (hit_vec[b]) begin
                done_mask = done_mask | cur_mask[b];
            end
            stall_next = stall_next | nxt_mask[b];
        end
    end

    // -----------------------------------------------------------------------
    // Release register, stall mask, duplicate pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rel_valid_reg   <= 1'b0;
            rel_bid_reg     <= '0;
            rel_mask_reg    <= '0;
            rel_timeout_reg <= 1'b0;
            stall_mask_reg  <= '0;
            err_dup_reg     <= 1'b0;
        end else begin
            if (any_done) begin
                rel_valid_reg   <= 1'b1;
                rel_bid_reg     <= req_bid;
                rel_mask_reg    <= done_mask;
                rel_timeout_reg <= 1'b0;
            end else if (any_grant) begin
                rel_valid_reg   <= 1'b1;
                rel_bid_reg     <= tout_bid;
                rel_mask_reg    <= tout_mask;
                rel_timeout_reg <= 1'b1;
            end else if (rel_valid_reg && rel_ready) begin
                rel_valid_reg   <= 1'b0;
                rel_bid_reg     <= '0;
                rel_mask_reg    <= '0;
                rel_timeout_reg <= 1'b0;
            end
            stall_mask_reg <= stall_next;
            err_dup_reg    <= |dup_vec;
        end
    end

    assign rel_valid   = rel_valid_reg;
    assign rel_bid     = rel_bid_reg;
    assign rel_mask    = rel_mask_reg;
    assign rel_timeout = rel_timeout_reg;
    assign stall_mask  = stall_mask_reg;
    assign err_dup     = err_dup_reg;

endmodule

// File: doc/vx_barrier_table.md
Name: vx_barrier_table

Overview:
- Multi-barrier warp synchronisation table for the core's issue/scheduler path.
- Consumes barrier arrival requests carrying {barrier id, size_m1}, tracks arrived warps per barrier and drives a per-warp stall mask.
- On completion, emits a release event with the mask of warps to unstall.
- Parametrised successor to the single fixed-width barrier record: configurable warp and barrier counts, back-pressured release, duplicate detection, optional timeout.

Parameters:
- NUM_WARPS, 4, warps per core (>=1)
- NUM_BARRIERS, 8, independent barrier entries (>=1)
- TIMEOUT_CYCLES, 65535, open-barrier lifetime before forced release (used only with the optional feature)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  arrival request valid
- req_ready  out  1  arrival accepted when valid&ready
- req_wid  in  NW=UP(CLOG2(NUM_WARPS))  arriving warp id
- req_bid  in  NB=UP(CLOG2(NUM_BARRIERS))  barrier id
- req_size_m1  in  NW  participating warps minus one
- rel_valid  out  1  release event valid
- rel_ready  in  1  consumer accepts release
- rel_bid  out  NB  released barrier id
- rel_mask  out  NUM_WARPS  warps to unstall
- rel_timeout  out  1  release was forced by timeout (0 when the feature is absent)
- stall_mask  out  NUM_WARPS  warps currently waiting at any barrier
- err_dup  out  1  one-cycle pulse: duplicate arrival ignored

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high (fixed).
- Per-entry state: active, count[NW], size_m1[NW], mask[NUM_WARPS]; plus a one-deep release register.
- Reset: all entries inactive with zero count/mask. rel_valid=0, rel_bid=0, rel_mask=0, rel_timeout=0, stall_mask=0, err_dup=0.
- Reset mid-operation discards pending releases; stalled warps are cleared.
- req_ready = !rel_valid || rel_ready. Exactly one arrival per cycle.
- Accepted arrival on an inactive entry:
  - entry becomes active; size_m1 is latched; mask = onehot(wid); count = 0.
  - If size_m1==0, the arrival completes immediately (see completion).
- Accepted arrival on an active entry:
  - If mask[wid] is already set: no state change; err_dup pulses the next cycle.
  - Otherwise mask|=onehot(wid) and count++.
  - req_size_m1 is ignored; the first arrival's size governs.
- Completion: arrival where (count_before_arrival+1)==size_m1, or size_m1==0 on the first arrival.
  - At that edge: the release register loads {bid, mask|onehot(wid)}, rel_timeout=0, and the entry returns to inactive with count=0, mask=0.
  - rel_valid is asserted the cycle after acceptance (latency 1).
- rel_valid holds with stable rel_bid/rel_mask/rel_timeout until rel_ready.
- The release register clears on rel_valid&rel_ready unless a new release loads in the same cycle (back-to-back allowed, since req_ready=1 then).
- stall_mask is registered: OR of all active entry masks, updated the same edge as entry state.
  - The completing warp never appears in stall_mask.
  - Previously waiting warps drop out of stall_mask at the completion edge.
- A completed barrier id is immediately reusable; a new arrival to it on the next cycle opens a fresh generation.
- count saturation is impossible because size_m1 <= NUM_WARPS-1 and duplicates are rejected.
- size_m1 > NUM_WARPS-1 is a programming error: the entry never completes (only timeout clears it).

Optional Feature:
- Macro: BARRIER_TIMEOUT_EN.
- Defined:
  - Each active entry has an age counter [CLOG2(TIMEOUT_CYCLES+1)], zeroed on activation and incremented every cycle while active.
  - At age==TIMEOUT_CYCLES the entry requests a forced release {bid, mask, rel_timeout=1}.
  - A forced release loads only in a cycle where no arrival completes and the release register is free or being drained. The lowest bid wins; others wait, holding age at the limit.
  - The entry deactivates when its forced release loads.
- Undefined: no age counters; rel_timeout is tied 0; stuck entries persist until reset.

Test Plan:
- NUM_WARPS=4: arrivals (w0,b2,size_m1=3),(w1,b2),(w2,b2) -> stall_mask 0001, 0011, 0111 after each; (w3,b2) -> next cycle rel_valid=1, rel_bid=2, rel_mask=1111, stall_mask=0000.
- Arrival (w1,b5,size_m1=0) -> no stall; rel_valid next cycle with rel_mask=0010, rel_bid=5.
- Open b0 with w0 (size_m1=1), then send w0 to b0 again -> err_dup pulses 1 cycle; count unchanged; w1 then completes with rel_mask=0011.
- Hold rel_ready=0 with a release pending -> req_ready=0 and rel_* stable for 10 cycles; on rel_ready=1, a queued completing arrival is accepted the same cycle and its release appears the next cycle.
- Barriers b1 and b3 interleaved (w0→b1, w1→b3, w2→b1, w3→b3, size_m1=1) -> two releases: b1 mask 0101, then b3 mask 1010.
- With BARRIER_TIMEOUT_EN and TIMEOUT_CYCLES=16: w2 opens b4 (size_m1=3), no further arrivals -> at cycle 17 after acceptance rel_valid=1, rel_timeout=1, rel_mask=0100; reset asserted mid-wait instead -> all outputs zero the next cycle.
